// File: rtl/condicionador_entrada.sv
// Input conditioning for the type-2 fuzzy core: per-period error / delta-error,
// saturated to signed 8-bit, presented offset-binary and held during the rule window.
module condicionador_entrada #(
    parameter int PERIODO   = 256,
    parameter int JANELA    = 64,
    parameter int ESCALA_DE = 0
) (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic [7:0] setpoint,
    input  logic [7:0] sensor,
    input  logic       sensor_valido,
    output logic [7:0] Entrada_01,
    output logic [7:0] Entrada_02,
    output logic       EN_REGRAS,
    output logic       amostra_ausente
);

    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int WW = $clog2(JANELA + 1);

    typedef enum logic [2:0] {OCIOSO, CALC_E, CALC_D, ATUALIZA, JAN} estado_t;

    estado_t estado, estado_prox;

    logic [CW-1:0]      cnt;
    logic [WW-1:0]      jan_cnt;
    logic               tick, tem_amostra, jan_fim;
    logic [7:0]         sensor_reg, setpoint_snap, sensor_snap;
    logic               amostra_ok, primeiro;
    logic signed [7:0]  e_sat, de_sat, e_prev;
    logic signed [9:0]  e_full, de_full, de_esc;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            sat8 = 8'sd127;
        else if (v < -10'sd128)
            sat8 = -8'sd128;
        else
            sat8 = v[7:0];
    endfunction

    assign tick        = (cnt == CW'(PERIODO - 1));
    assign tem_amostra = amostra_ok | sensor_valido;
    assign jan_fim     = (jan_cnt == WW'(1));

    // Full-width arithmetic so saturation never sees a wrapped value
    always_comb begin
        e_full  = $signed({2'b00, setpoint_snap}) - $signed({2'b00, sensor_snap});
        de_full = $signed({{2{e_sat[7]}}, e_sat}) - $signed({{2{e_prev[7]}}, e_prev});
        de_esc  = de_full >>> ESCALA_DE;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:   if (tick && tem_amostra) estado_prox = CALC_E;
            CALC_E:   estado_prox = CALC_D;
            CALC_D:   estado_prox = ATUALIZA;
            ATUALIZA: estado_prox = JAN;
            JAN:      if (jan_fim) estado_prox = OCIOSO;
            default:  estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (Srst)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_ff @(posedge clk_0) begin
        if (Srst || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Capture runs in every state; the tick-time clear below overrides it so a
    // strobe on the tick itself is consumed through the bypass path.
    always_ff @(posedge clk_0) begin
        if (Srst) begin
            sensor_reg      <= '0;
            amostra_ok      <= 1'b0;
            setpoint_snap   <= '0;
            sensor_snap     <= '0;
            e_sat           <= '0;
            de_sat          <= '0;
            e_prev          <= '0;
            primeiro        <= 1'b1;
            jan_cnt         <= '0;
            Entrada_01      <= 8'd128;
            Entrada_02      <= 8'd128;
            EN_REGRAS       <= 1'b0;
            amostra_ausente <= 1'b0;
        end else begin
            if (sensor_valido) begin
                sensor_reg <= sensor;
                amostra_ok <= 1'b1;
            end
            case (estado)
                OCIOSO: begin
                    if (tick) begin
                        if (tem_amostra) begin
                            setpoint_snap <= setpoint;
                            sensor_snap   <= sensor_valido ? sensor : sensor_reg;
                            amostra_ok    <= 1'b0;
                        end else begin
                            amostra_ausente <= 1'b1;
                        end
                    end
                end
                CALC_E: e_sat <= sat8(e_full);
                CALC_D: de_sat <= primeiro ? 8'sd0 : sat8(de_esc);
                ATUALIZA: begin
                    Entrada_01 <= {~e_sat[7], e_sat[6:0]};
                    Entrada_02 <= {~de_sat[7], de_sat[6:0]};
                    e_prev     <= e_sat;
                    primeiro   <= 1'b0;
                    jan_cnt    <= WW'(JANELA);
                    EN_REGRAS  <= 1'b1;
                end
                JAN: begin
                    if (jan_fim) begin
                        jan_cnt   <= '0;
                        EN_REGRAS <= 1'b0;
                    end else begin
                        jan_cnt <= jan_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
